div_unit: RTL
=============

// Module: div_unit
//
// PURPOSE
//   Sequential 32-bit signed restoring divider answering the ctrl_DIV request of the
//   multdiv handshake. Issuer pulses ctrl_DIV with operands valid; unit iterates one
//   quotient bit per cycle, then pulses data_resultRDY with quotient/remainder/exception.
//   Sits beside the multiplier under multdiv; the pipeline stalls on busy.
//
// PARAMETERS
//   WIDTH   32   operand/result width (only 32 is verified)
//
// PORTS
//   clock           in   1      single clock, rising edge
//   reset_n         in   1      asynchronous, active-low reset
//   ctrl_DIV        in   1      start request, sampled on rising edge (one-cycle pulse)
//   data_operandA   in   WIDTH  dividend, signed two's complement, valid with ctrl_DIV
//   data_operandB   in   WIDTH  divisor, signed, valid with ctrl_DIV
//   data_result     out  WIDTH  quotient, truncated toward zero
//   data_remainder  out  WIDTH  remainder, sign of dividend
//   data_exception  out  1      divide-by-zero or overflow; valid while data_resultRDY=1
//   data_resultRDY  out  1      one-cycle completion pulse
//   busy            out  1      high from cycle after start through the DONE cycle
//
// BEHAVIOUR
// - Reset (async, reset_n=0): state IDLE; data_result, data_remainder, count = 0;
//   data_exception, data_resultRDY, busy = 0. Reset mid-operation aborts with no RDY pulse.
// - Operands latched only on an edge with ctrl_DIV=1; later operand changes are ignored.
// - FSM: IDLE -> RUN (ctrl_DIV=1, B!=0, not overflow case) | DONE (B==0 or A=0x80000000,B=-1).
//   RUN: 32 iterations, count 0..31; at count==31 -> FIX. FIX: apply signs -> DONE.
//   DONE: data_resultRDY=1 for exactly one cycle -> IDLE.
// - Latency, cycle 0 = cycle ctrl_DIV is high: normal RDY in cycle 34; exception RDY in cycle 1.
// - Iteration: magnitudes |A|,|B| (33-bit internally so |0x80000000| is exact);
//   R' = {R[WIDTH-1:0], Q[WIDTH-1]}; if R' >= |B| then R'-=|B|, shift in 1 else 0.
// - FIX: quotient negated iff sign(A)^sign(B); remainder negated iff sign(A).
// - Divide by zero: data_result=0, data_remainder=0, data_exception=1.
// - Overflow 0x80000000 / -1: data_result=0x80000000, data_remainder=0, data_exception=1.
// - data_exception=0 on every normal completion; all outputs hold until next start.
// - ctrl_DIV while busy (RUN/FIX/DONE): current op abandoned, new operands latched,
//   FSM restarts as from IDLE; no RDY for the abandoned op.
// - busy=0 in IDLE; issuer may start in the cycle after RDY.
//
// STRUCTURE
// - Shared include (multdiv_defs.vh): WIDTH, FSM state encodings (IDLE/RUN/FIX/DONE),
//   iteration-count width (5 bits); multiplier uses the same file.
// - Sub-module div_step: combinational single iteration
//   (R, Q, |B|) -> (R', Q'), one compare-subtract; instantiated once, fed from registers.
// - Top: FSM, counter, operand/sign registers, sign fix-up, exception detect.
//
// TESTING
// - 7 / 3 -> result 2, remainder 1, exception 0, RDY exactly cycle 34, busy cycles 1..34.
// - -7 / 2 -> result 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); 7 / -2 -> -3, remainder 1.
// - 5 / 0 -> result 0, remainder 0, exception 1, RDY cycle 1, no RUN cycles.
// - 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exception 1, RDY cycle 1;
//   0x80000000 / 2 -> 0xC0000000, remainder 0, exception 0.
// - Start 100/7, re-pulse ctrl_DIV with 9/4 at cycle 10 -> one RDY only, 34 cycles after
//   second pulse, result 2, remainder 1.
// - reset_n low at cycle 15 of a run -> all outputs 0 immediately (async), no RDY;
//   next 7/3 completes normally.
// - Random: 10k signed pairs vs reference model; check A == Q*B + R and |R| < |B|.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the signed restoring divider: widths and FSM state encoding.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor magnitude if it fits, and shift in the quotient bit.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH:0]   b_mag,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] r_shift;
  logic           take;

  // The partial remainder stays below |B| <= 2^(WIDTH-1), so WIDTH bits hold it.
  always_comb begin
    r_shift = {r, q[WIDTH-1]};
    take    = (r_shift >= b_mag);
    r_next  = take ? WIDTH'(r_shift - b_mag) : r_shift[WIDTH-1:0];
    q_next  = {q[WIDTH-2:0], take};
  end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider: magnitudes are divided one bit per cycle, then signs are
// applied. Handshake: ctrl_DIV is a one-cycle start pulse sampled on the rising edge
// (it restarts the unit even while busy); data_resultRDY is a one-cycle completion
// pulse and results/exception hold until the next completion.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output div_state_e       state_dbg
);

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH:0]   b_mag_reg;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH:0]   b_mag;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] step_q;

  // |0x80000000| is representable as an unsigned WIDTH-bit magnitude.
  always_comb begin
    a_mag    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag    = {1'b0, (data_operandB[WIDTH-1] ? -data_operandB : data_operandB)};
    div_zero = (data_operandB == '0);
    overflow = (data_operandA == MIN_VAL) && (data_operandB == '1);
  end

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .b_mag  (b_mag_reg),
    .r_next (step_r),
    .q_next (step_q)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      count          <= '0;
      q_reg          <= '0;
      r_reg          <= '0;
      b_mag_reg      <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        count     <= '0;
        busy      <= 1'b1;
        q_reg     <= a_mag;
        r_reg     <= '0;
        b_mag_reg <= b_mag;
        neg_q     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        neg_r     <= data_operandA[WIDTH-1];
        if (div_zero || overflow) begin
          state          <= ST_DONE;
          data_result    <= div_zero ? '0 : MIN_VAL;
          data_remainder <= '0;
          data_exception <= 1'b1;
          data_resultRDY <= 1'b1;
        end else begin
          state <= ST_RUN;
        end
      end else begin
        case (state)
          ST_RUN: begin
            r_reg <= step_r;
            q_reg <= step_q;
            count <= count + 1'b1;
            if (count == LAST_CNT) state <= ST_FIX;
          end
          ST_FIX: begin
            data_result    <= neg_q ? -q_reg : q_reg;
            data_remainder <= neg_r ? -r_reg : r_reg;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b1;
            state          <= ST_DONE;
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule
